// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: access size codes and FSM states.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  // True when the size code is reserved or the byte offset breaks natural alignment.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: access_bad = 1'b0;
      SZ_HALF: access_bad = lane[0];
      SZ_WORD: access_bad = (lane != 2'b00);
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mau_align.sv
// Lane extract/extend for loads and read-modify-write lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mau_align
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Pick the addressed byte/half (little-endian) and extend it to 32 bits.
  always_comb begin
    sel_b = rword[7:0];
    case (lane)
      2'd1:    sel_b = rword[15:8];
      2'd2:    sel_b = rword[23:16];
      2'd3:    sel_b = rword[31:24];
      default: sel_b = rword[7:0];
    endcase
    sel_h = lane[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{sext & sel_b[7]}}, sel_b};
      SZ_HALF: load_data = {{16{sext & sel_h[15]}}, sel_h};
      default: load_data = rword;
    endcase
  end

  // Overwrite only the addressed lane(s) of the word read back from memory.
  always_comb begin
    merged = rword;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit: byte/half/word access to a word-wide data memory with sub-word RMW.
// Latency from accept edge to done_o: error 1, load 2, word store 2, sub-word store 3 cycles.
// Backpressure: busy_o high outside IDLE; req_i is ignored until the FSM is back in IDLE.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [31:0]       dm_din_o,
  output logic              dm_wr_o,
  input  logic [31:0]       dm_dout_i
);

  state_t            st;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  // Memory only ever sees word-aligned addresses; the lane is handled in mau_align.
  assign dm_addr_o = {addr_q[ADDR_W-1:2], 2'b00};

  mau_align u_align (
    .size      (size_q),
    .sext      (sext_q),
    .lane      (addr_q[1:0]),
    .rword     (dm_dout_i),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Access sequencer: all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
      dm_din_o <= '0;
      dm_wr_o  <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          if (req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            sext_q  <= sext_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            busy_o  <= 1'b1;
            if (access_bad(size_i, addr_i[1:0])) begin
              st     <= ST_DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else if (!we_i) begin
              st <= ST_LOAD;
            end else if (size_i == SZ_WORD) begin
              // Full-word store needs no read-back, so the write word is known now.
              st       <= ST_WRITE;
              dm_din_o <= wdata_i;
              dm_wr_o  <= 1'b1;
            end else begin
              st <= ST_READ;
            end
          end
        end
        ST_LOAD, ST_READ: begin
          // Both states sample the memory word; stores merge it, loads return a lane.
          if (we_q) begin
            st       <= ST_WRITE;
            dm_din_o <= merged;
            dm_wr_o  <= 1'b1;
          end else begin
            st      <= ST_DONE;
            rdata_o <= load_data;
            done_o  <= 1'b1;
          end
        end
        ST_WRITE: begin
          st      <= ST_DONE;
          dm_wr_o <= 1'b0;
          done_o  <= 1'b1;
        end
        ST_DONE: begin
          st     <= ST_IDLE;
          done_o <= 1'b0;
          err_o  <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          st     <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide falling-edge data memory model.
// Latency: checks done_o timing per access class against hand-computed cycle counts.
// Backpressure: exercises req_i held high while busy to confirm single acceptance.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sext_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_din_o;
  logic        dm_wr_o;
  logic [31:0] dm_dout_i;

  logic [31:0] mem [0:15] = '{4: 32'h8899AABB, default: 32'h0};
  int          wr_cnt = 0;
  logic [31:0] last_din = 32'h0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .size_i    (size_i),
    .sext_i    (sext_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .dm_addr_o (dm_addr_o),
    .dm_din_o  (dm_din_o),
    .dm_wr_o   (dm_wr_o),
    .dm_dout_i (dm_dout_i)
  );

  assign dm_dout_i = mem[dm_addr_o[5:2]];

  always @(negedge clk) begin
    if (dm_wr_o) begin
      mem[dm_addr_o[5:2]] <= dm_din_o;
      last_din = dm_din_o;
      wr_cnt   = wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, measure edges to done_o, then let the FSM return to IDLE.
  task automatic access(input logic we, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output logic b1, output logic [31:0] a1);
    req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
    tick();
    req_i = 1'b0;
    b1  = busy_o;
    a1  = dm_addr_o;
    lat = 1;
    while (!done_o && lat < 10) begin
      tick();
      lat++;
    end
    e = err_o;
    if (!done_o) lat = 99;
    tick();
  endtask

  initial begin
    int          lat;
    logic        e;
    logic        b1;
    logic [31:0] a1;
    int          w0;
    int          dones;

    rst = 1'b1; req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; sext_i = 1'b0;
    addr_i = 32'h10; wdata_i = 32'hDEADBEEF;
    tick();
    tick();
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_wr", {31'd0, dm_wr_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr", dm_addr_o, 32'd0);
    req_i = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_no_write", mem[4], 32'h8899AABB);

    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, e, b1, a1);
    check("lb_sext_data", rdata_o, 32'hFFFFFFAA);
    check("lb_sext_lat", lat, 2);
    check("lb_sext_err", {31'd0, e}, 32'd0);
    check("lb_busy", {31'd0, b1}, 32'd1);
    check("lb_dm_addr", a1, 32'h10);

    access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, e, b1, a1);
    check("lhu_data", rdata_o, 32'h00008899);
    check("lhu_lat", lat, 2);
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, e, b1, a1);
    check("lh_sext_data", rdata_o, 32'hFFFFAABB);
    access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, e, b1, a1);
    check("lbu_data", rdata_o, 32'h000000BB);
    access(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, e, b1, a1);
    check("lw_data", rdata_o, 32'h8899AABB);

    w0 = wr_cnt;
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h1234565C, lat, e, b1, a1);
    check("sb_wr_pulses", wr_cnt - w0, 1);
    check("sb_din", last_din, 32'h5C99AABB);
    check("sb_mem", mem[4], 32'h5C99AABB);
    check("sb_lat", lat, 3);
    check("sb_err", {31'd0, e}, 32'd0);

    access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, lat, e, b1, a1);
    check("sh_mem", mem[4], 32'hBEEFAABB);
    check("sh_lat", lat, 3);

    w0 = wr_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h06, 32'h11111111, lat, e, b1, a1);
    check("sw_mis_err", {31'd0, e}, 32'd1);
    check("sw_mis_lat", lat, 1);
    check("sw_mis_nowr", wr_cnt - w0, 0);
    check("sw_mis_rdata", rdata_o, 32'h8899AABB);
    check("err_clear", {31'd0, err_o}, 32'd0);

    access(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, e, b1, a1);
    check("lh_mis_err", {31'd0, e}, 32'd1);
    check("lh_mis_rdata", rdata_o, 32'h8899AABB);
    access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, e, b1, a1);
    check("rsvd_err", {31'd0, e}, 32'd1);
    check("rsvd_lat", lat, 1);

    w0 = wr_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, lat, e, b1, a1);
    check("sw_lat", lat, 2);
    check("sw_mem", mem[8], 32'hCAFEF00D);
    check("sw_wr_pulses", wr_cnt - w0, 1);

    // Reset while the byte store is still reading back the word.
    w0 = wr_cnt;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; sext_i = 1'b0; addr_i = 32'h10; wdata_i = 32'h77;
    tick();
    req_i = 1'b0;
    check("rd_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rd_rst_busy", {31'd0, busy_o}, 32'd0);
    check("rd_rst_wr", {31'd0, dm_wr_o}, 32'd0);
    check("rd_rst_rdata", rdata_o, 32'd0);
    tick();
    check("rd_rst_nowr", wr_cnt - w0, 0);
    check("rd_rst_mem", mem[4], 32'hBEEFAABB);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, b1, a1);
    check("rd_rst_reload", rdata_o, 32'hBEEFAABB);

    // Reset while in WRITE: the falling-edge commit stands, the enable drops.
    w0 = wr_cnt;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; sext_i = 1'b0; addr_i = 32'h10; wdata_i = 32'h3D;
    tick();
    req_i = 1'b0;
    tick();
    check("wr_state_wr", {31'd0, dm_wr_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wr_rst_wr", {31'd0, dm_wr_o}, 32'd0);
    check("wr_rst_mem", mem[4], 32'hBEEFAA3D);
    check("wr_rst_pulses", wr_cnt - w0, 1);
    tick();

    // req_i held high: accepts only from IDLE, one per four-cycle sub-word store.
    w0 = wr_cnt;
    dones = 0;
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; sext_i = 1'b0; addr_i = 32'h19; wdata_i = 32'h11;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_o) dones++;
    end
    req_i = 1'b0;
    check("hold_busy_end", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o) dones++;
    end
    check("hold_wr_pulses", wr_cnt - w0, 3);
    check("hold_dones", dones, 3);
    check("hold_mem", mem[6], 32'h00001100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, width of byte address on both sides.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_i  in  1  CPU access request; sampled only in IDLE.
REQ-005 we_i  in  1  1 = store, 0 = load.
REQ-006 size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 sext_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr_i  in  ADDR_W  byte address.
REQ-009 wdata_i  in  32  store data; sub-word stores use its low byte/half.
REQ-010 busy_o  out  1  high in every state except IDLE.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 err_o  out  1  valid with done_o: misaligned access or reserved size.
REQ-013 rdata_o  out  32  load result; held until the next accepted request.
REQ-014 dm_addr_o  out  ADDR_W  word-aligned address to data memory (low 2 bits 0).
REQ-015 dm_din_o  out  32  write word to data memory.
REQ-016 dm_wr_o  out  1  memory write enable; memory commits on falling edge of clk.
REQ-017 dm_dout_i  in  32  combinational read word from data memory at dm_addr_o.

Function
REQ-018 FSM states SHALL be: IDLE, LOAD, READ, WRITE, DONE.
REQ-019 In IDLE with req_i=1, unit SHALL latch we_i, size_i, sext_i, addr_i, wdata_i and leave IDLE on the next edge; requests arriving while busy_o=1 SHALL be ignored.
REQ-020 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL go IDLE->DONE with err_o=1, no memory write, rdata_o unchanged.
REQ-021 Valid load SHALL go IDLE->LOAD->DONE: in LOAD, capture dm_dout_i, extract lane by addr[1:0], extend per sext_i, write rdata_o.
REQ-022 Word store SHALL go IDLE->WRITE->DONE.
REQ-023 Byte/half store SHALL go IDLE->READ->WRITE->DONE: READ captures dm_dout_i; merge replaces only addressed lane(s), little-endian (byte n = bits 8n+7:8n).
REQ-024 dm_wr_o SHALL be 1 only in WRITE, for exactly one cycle; dm_din_o SHALL be stable for that whole cycle.
REQ-025 dm_addr_o SHALL equal latched addr with bits [1:0] forced to 0 in LOAD, READ, WRITE.
REQ-026 DONE SHALL last one cycle with done_o=1, then return to IDLE; a new req_i is accepted no earlier than that IDLE cycle.
REQ-027 Latency from accepting edge to done_o: err 1 cycle, load 2, word store 2, sub-word store 3.
REQ-028 err_o SHALL be 0 whenever done_o is 0.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, busy_o=0, done_o=0, err_o=0, dm_wr_o=0, rdata_o=0, latched registers=0, regardless of state.
REQ-030 Reset asserted while in WRITE SHALL deassert dm_wr_o from the next rising edge; a write already committed on the preceding falling edge is not undone.
REQ-031 rst has priority over req_i in the same cycle.

Structure
REQ-032 Shared package mau_pkg SHALL hold size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-033 Lane extract/extend and store merge SHALL live in one combinational sub-module, mau_align.

Verification
REQ-034 Mem word 0x8899AABB at 0x10; load byte addr 0x11 sext=1 -> rdata_o=0xFFFFFFAA, done_o 2 cycles after accept, err_o=0.
REQ-035 Same word; load half addr 0x12 sext=0 -> rdata_o=0x00008899.
REQ-036 Same word; store byte 0x5C to 0x13 -> one dm_wr_o pulse, dm_din_o=0x5C99AABB, done_o 3 cycles after accept.
REQ-037 Store word addr 0x06 -> err_o=1 with done_o 1 cycle after accept, dm_wr_o never asserted.
REQ-038 Reset asserted during READ of a byte store -> IDLE next edge, no dm_wr_o, memory word unchanged; next load returns original data.
REQ-039 req_i held high throughout a sub-word store -> exactly one request accepted per DONE->IDLE, none while busy_o=1.
